// File: rtl/mips16_pkg.sv
// Shared definitions for the MIPS16 instruction-memory loader.
// Holds the loader state encoding, instruction word width and default reset hold.
package mips16_pkg;

  localparam int INSTR_W            = 16;
  localparam int DEFAULT_RESET_HOLD = 4;

  typedef enum logic [2:0] {
    LEN  = 3'd0,
    DATA = 3'd1,
    CSUM = 3'd2,
    HOLD = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/mips16_imem_loader.sv
// Boot loader: length-prefixed word stream -> imem writes from addr 0, then core reset release; optional trailing checksum under MIPS16_LOADER_CHECKSUM_EN.
// Latency: imem write registered one cycle after accept; core_reset falls RESET_HOLD+1 cycles after the last accept.
// Backpressure: in_ready depends only on state/reset; drops in HOLD/RUN/ERR, never stalls mid-stream.
module mips16_imem_loader
  import mips16_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int RESET_HOLD = DEFAULT_RESET_HOLD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               core_reset,
  output logic               load_done,
  output logic               load_err,
  output logic [ADDR_W:0]    words_loaded
);

  localparam int unsigned          DEPTH     = 1 << ADDR_W;
  localparam int                   CNT_W     = $clog2(RESET_HOLD + 1);
  localparam logic [CNT_W-1:0]     HOLD_INIT = CNT_W'(RESET_HOLD);

  loader_state_t      state;
  logic [ADDR_W:0]    len;
  logic [CNT_W-1:0]   hold_cnt;
  logic [ADDR_W:0]    wl_nxt;
  logic               accept;
`ifdef MIPS16_LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] sum;
`endif

  assign in_ready = !reset && (state == LEN || state == DATA || state == CSUM);
  assign accept   = in_valid && in_ready;
  assign wl_nxt   = words_loaded + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LEN;
      len          <= '0;
      hold_cnt     <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_reset   <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
`ifdef MIPS16_LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        LEN: if (accept) begin
          if (in_data == '0) begin
`ifdef MIPS16_LOADER_CHECKSUM_EN
            state    <= CSUM;
`else
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
`endif
          end else if (32'(in_data) > DEPTH) begin
            // Oversized length is rejected before any write can happen
            state    <= ERR;
            load_err <= 1'b1;
          end else begin
            len   <= (ADDR_W+1)'(in_data);
            state <= DATA;
          end
        end
        DATA: if (accept) begin
          imem_we      <= 1'b1;
          imem_addr    <= words_loaded[ADDR_W-1:0];
          imem_wdata   <= in_data;
          words_loaded <= wl_nxt;
`ifdef MIPS16_LOADER_CHECKSUM_EN
          sum          <= sum + in_data;
          if (wl_nxt == len) state <= CSUM;
`else
          if (wl_nxt == len) begin
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
          end
`endif
        end
`ifdef MIPS16_LOADER_CHECKSUM_EN
        CSUM: if (accept) begin
          if (in_data == sum) begin
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
          end else begin
            state    <= ERR;
            load_err <= 1'b1;
          end
        end
`endif
        HOLD: begin
          // Counter expiring one edge after zero gives RESET_HOLD+1 cycles total
          if (hold_cnt == '0) begin
            state      <= RUN;
            core_reset <= 1'b0;
            load_done  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        RUN: ;
        ERR: ;
        default: begin
          state    <= ERR;
          load_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips16_imem_loader.sv
// Directed bench for mips16_imem_loader (ADDR_W=8, RESET_HOLD=4); checksum steps follow MIPS16_LOADER_CHECKSUM_EN.
module tb_mips16_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        core_reset;
  logic        load_done;
  logic        load_err;
  logic [8:0]  words_loaded;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];

  mips16_imem_loader #(.ADDR_W(8), .RESET_HOLD(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (imem_we === 1'b1) begin
      wr_addr.push_back(int'(imem_addr));
      wr_data.push_back(int'(imem_wdata));
      wr_cyc.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_words", words_loaded, 0);
    reset = 1'b0;
    #1;
    chk("len_in_ready", in_ready, 1);
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
  endtask

  task automatic send(input logic [15:0] w);
    in_valid = 1'b1; in_data = w;
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) begin
        tick();
        return;
      end
      tick();
    end
    chk("send_ready_timeout", in_ready, 1);
  endtask

  // Called right after the last accepting edge: release lands on the 5th edge.
  task automatic expect_release(input string tag);
    in_valid = 1'b0;
    chk({tag, "_hold_ready"}, in_ready, 0);
    for (int i = 0; i < 4; i++) tick();
    chk({tag, "_hold_core_reset"}, core_reset, 1);
    chk({tag, "_hold_done"}, load_done, 0);
    tick();
    chk({tag, "_core_reset"}, core_reset, 0);
    chk({tag, "_done"}, load_done, 1);
    chk({tag, "_err"}, load_err, 0);
  endtask

  initial begin
    logic [15:0] s;

    // Three words back-to-back
    do_reset();
    send(16'd3); send(16'h2001); send(16'h2402); send(16'h0123);
`ifdef MIPS16_LOADER_CHECKSUM_EN
    send(16'h4526);
`else
    chk("t1_last_write_in_hold", {imem_we, in_ready}, 2'b10);
`endif
    expect_release("t1");
    chk("t1_nwr", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      chk("t1_a0", wr_addr[0], 0); chk("t1_d0", wr_data[0], 32'h2001);
      chk("t1_a1", wr_addr[1], 1); chk("t1_d1", wr_data[1], 32'h2402);
      chk("t1_a2", wr_addr[2], 2); chk("t1_d2", wr_data[2], 32'h0123);
      chk("t1_gap01", wr_cyc[1] - wr_cyc[0], 1);
      chk("t1_gap12", wr_cyc[2] - wr_cyc[1], 1);
    end
    chk("t1_words", words_loaded, 3);

    // Zero length
    do_reset();
    send(16'd0);
`ifdef MIPS16_LOADER_CHECKSUM_EN
    send(16'h0000);
`endif
    expect_release("t2");
    chk("t2_nwr", wr_addr.size(), 0);
    chk("t2_words", words_loaded, 0);

    // Oversized length, then input ignored
    do_reset();
    send(16'd257);
    in_valid = 1'b0;
    chk("t3_err", load_err, 1);
    chk("t3_ready", in_ready, 0);
    chk("t3_core_reset", core_reset, 1);
    in_valid = 1'b1; in_data = 16'h1111;
    for (int i = 0; i < 6; i++) tick();
    in_valid = 1'b0;
    chk("t3_nwr", wr_addr.size(), 0);
    chk("t3_err_sticky", load_err, 1);
    chk("t3_done", load_done, 0);
    chk("t3_ready_after", in_ready, 0);
    chk("t3_core_reset_after", core_reset, 1);

    // Full-depth load, last address 255
    do_reset();
    s = '0;
    send(16'd256);
    for (int i = 0; i < 256; i++) begin
      send(16'(i * 3 + 1));
      s = s + 16'(i * 3 + 1);
    end
`ifdef MIPS16_LOADER_CHECKSUM_EN
    send(s);
`endif
    expect_release("t4");
    chk("t4_nwr", wr_addr.size(), 256);
    if (wr_addr.size() == 256) begin
      chk("t4_last_addr", wr_addr[255], 255);
      chk("t4_last_data", wr_data[255], 766);
    end
    chk("t4_words", words_loaded, 256);

    // in_valid toggling across 4 words
    do_reset();
    send(16'd4);
    for (int i = 0; i < 4; i++) begin
      send(16'h0A00 + 16'(i));
      in_valid = 1'b0;
      tick();
    end
`ifdef MIPS16_LOADER_CHECKSUM_EN
    send(16'h2806);
    in_valid = 1'b0;
    chk("t5_err", load_err, 0);
`endif
    for (int i = 0; i < 8; i++) tick();
    chk("t5_nwr", wr_addr.size(), 4);
    if (wr_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t5_addr", wr_addr[i], i);
        chk("t5_data", wr_data[i], 32'h0A00 + i);
      end
      chk("t5_gap", wr_cyc[3] - wr_cyc[0], 6);
    end
    chk("t5_done", load_done, 1);

`ifdef MIPS16_LOADER_CHECKSUM_EN
    // Checksum mismatch
    do_reset();
    send(16'd2); send(16'h0001); send(16'h0002); send(16'h0004);
    in_valid = 1'b0;
    chk("t6_err", load_err, 1);
    for (int i = 0; i < 6; i++) tick();
    chk("t6_nwr", wr_addr.size(), 2);
    chk("t6_err_sticky", load_err, 1);
    chk("t6_done", load_done, 0);
    chk("t6_core_reset", core_reset, 1);
`endif

    // Reset mid-load, then fresh single-word stream
    do_reset();
    send(16'd5); send(16'h1234); send(16'h5678);
    in_valid = 1'b0;
    chk("t7_partial_words", words_loaded, 2);
    do_reset();
    send(16'd1); send(16'hABCD);
`ifdef MIPS16_LOADER_CHECKSUM_EN
    send(16'hABCD);
`endif
    expect_release("t7");
    chk("t7_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      chk("t7_addr", wr_addr[0], 0);
      chk("t7_data", wr_data[0], 32'hABCD);
    end
    chk("t7_words", words_loaded, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mips16_imem_loader.md
# mips16_imem_loader

Boot-time instruction-memory loader for the 16-bit single-cycle MIPS core. It holds the core in reset and accepts a length-prefixed stream of 16-bit instruction words over a valid/ready handshake. It writes each word into instruction memory at consecutive addresses from 0, then releases the core reset after a fixed hold period. It is the writing end of the instruction-memory interface that the core's fetch path reads, and it replaces bench-driven reset sequencing with a hardware bring-up path.

## Interface
- ADDR_W, 8, instruction-memory address width; depth = 2^ADDR_W words
- RESET_HOLD, 4, cycles core_reset stays high after the last accepted word (≥1)

Clock and reset are fixed: one clock; reset is synchronous and active-high (`clk`, `reset`).

- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous active-high reset
- in_valid  in  1  stream word present
- in_data  in  16  stream word: length, then instructions, then optional checksum
- in_ready  out  1  loader accepts a word this cycle
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  16  write data
- core_reset  out  1  reset to the MIPS core; active-high
- load_done  out  1  load complete, core running; sticky until reset
- load_err  out  1  load aborted; sticky until reset
- words_loaded  out  ADDR_W+1  count of instruction words written

## Operation
- A word is accepted on a rising edge where in_valid && in_ready.
- States:
  - LEN: in_ready=1. An accepted word N is the length.
    - N=0 -> HOLD, no writes.
    - N>2^ADDR_W -> ERR.
    - Otherwise -> DATA.
  - DATA: in_ready=1. Each accepted word is written at addr = words_loaded, then words_loaded increments.
    - After the Nth word -> CSUM (macro defined) or HOLD.
  - CSUM: in_ready=1. One accepted word is compared with the running sum.
    - Equal -> HOLD.
    - Otherwise -> ERR.
  - HOLD: in_ready=0. A down-counter is loaded with RESET_HOLD; -> RUN when it reaches 0.
  - RUN: core_reset=0, load_done=1, in_ready=0. Terminal state.
  - ERR: core_reset=1, load_err=1, in_ready=0. Terminal state.
- Only reset leaves RUN or ERR. Input in those states is ignored.
- Reset values:
  - state=LEN
  - in_ready=0 while reset is high
  - imem_we=0, imem_addr=0, imem_wdata=0
  - core_reset=1, load_done=0, load_err=0, words_loaded=0
- Addresses do not wrap. N is length-checked up front, so the write at address 2^ADDR_W−1 is the last possible write.
- Reset mid-load aborts immediately. Memory contents already written are left in place. The next stream restarts at LEN.

## Timing
- imem_we, imem_addr and imem_wdata are registered. They assert in the cycle after acceptance, for exactly one cycle per word.
- Back-to-back accepts give one write per cycle. in_valid gaps insert idle cycles with imem_we=0.
- HOLD is entered on the edge that accepts the last word (data or checksum). The final imem write and the first HOLD cycle coincide.
- core_reset falls exactly RESET_HOLD+1 cycles after the last accepting edge. load_done rises on the same edge.
- The ERR transition takes effect on the accepting edge of the offending word. A bad length or checksum never causes a write.
- in_ready is combinational from state and reset only. It has no dependence on in_valid.

## Configuration
- MIPS16_LOADER_CHECKSUM_EN defined:
  - The stream ends with one checksum word equal to the sum of the N instruction words mod 2^16.
  - For N=0 the checksum is 0x0000.
  - A mismatch causes ERR.
- Undefined:
  - The CSUM state and the sum accumulator are absent.
  - DATA (or LEN with N=0) goes straight to HOLD.

## Structure
- Shared package mips16_pkg holds:
  - the loader state enum (LEN, DATA, CSUM, HOLD, RUN, ERR)
  - the instruction word width constant (16)
  - the default RESET_HOLD
- Single flat module. No sub-module is warranted. The checksum accumulator is an inline register under the macro.

## Test plan
- Stream 3, 0x2001, 0x2402, 0x0123 with in_valid held high (checksum 0x4526 if enabled):
  - writes go to addr 0, 1, 2 in consecutive cycles
  - words_loaded=3
  - core_reset falls 5 cycles after the last accept with RESET_HOLD=4
- Stream length 0:
  - no imem_we
  - HOLD entered directly
  - load_done=1 after RESET_HOLD+1 cycles
- Length 257 with ADDR_W=8:
  - load_err=1 on the next cycle
  - no writes
  - core_reset stays 1
  - in_ready=0 thereafter
- in_valid toggling every other cycle across 4 words:
  - exactly 4 single-cycle write strobes
  - addresses 0–3 with no gaps in the address sequence
- Checksum mismatch (macro defined), words 0x0001, 0x0002 with checksum 0x0004:
  - both words written
  - load_err=1
  - load_done=0
- Reset asserted after 2 of 5 data words, then a fresh stream of length 1 with word 0xABCD:
  - 0xABCD written at addr 0
  - words_loaded=1
  - load_done=1
